// File: rtl/alu_arbiter_if.sv
// Requester, response and ALU-side signals of the two-port ALU arbiter.
// The arbiter takes the slave side; requesters and the ALU sit on the master side.
interface alu_arbiter_if #(
  parameter int BUS_WIDTH = 8
);
  logic                 req0_valid, req0_ready;
  logic [BUS_WIDTH-1:0] req0_a, req0_b;
  logic [3:0]           req0_cmd;
  logic                 rsp0_valid, rsp0_ready, rsp0_flag;
  logic [BUS_WIDTH-1:0] rsp0_out;

  logic                 req1_valid, req1_ready;
  logic [BUS_WIDTH-1:0] req1_a, req1_b;
  logic [3:0]           req1_cmd;
  logic                 rsp1_valid, rsp1_ready, rsp1_flag;
  logic [BUS_WIDTH-1:0] rsp1_out;

  logic [BUS_WIDTH-1:0] alu_a, alu_b, alu_out;
  logic [3:0]           alu_command;
  logic                 alu_overflow;

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_cmd, rsp0_ready,
    input  req1_valid, req1_a, req1_b, req1_cmd, rsp1_ready,
    output req0_ready, rsp0_valid, rsp0_out, rsp0_flag,
    output req1_ready, rsp1_valid, rsp1_out, rsp1_flag,
    output alu_a, alu_b, alu_command,
    input  alu_out, alu_overflow
  );

  modport master (
    output req0_valid, req0_a, req0_b, req0_cmd, rsp0_ready,
    output req1_valid, req1_a, req1_b, req1_cmd, rsp1_ready,
    input  req0_ready, rsp0_valid, rsp0_out, rsp0_flag,
    input  req1_ready, rsp1_valid, rsp1_out, rsp1_flag,
    input  alu_a, alu_b, alu_command,
    output alu_out, alu_overflow
  );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one combinational ALU between two requesters.
// One op in flight: IDLE (grant) -> EXEC (capture ALU result) -> RESP (hold until taken).
module alu_arbiter #(
  parameter int BUS_WIDTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  alu_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t                        state_q, state_d;
  logic                          prio_q, prio_d, owner_q, owner_d;
  logic [BUS_WIDTH-1:0]          alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic [3:0]                    alu_cmd_q, alu_cmd_d;
  logic [1:0]                    rsp_valid_q, rsp_valid_d, rsp_flag_q, rsp_flag_d;
  logic [1:0][BUS_WIDTH-1:0]     rsp_out_q, rsp_out_d;

  logic [1:0]                    req_valid, rsp_ready, grant;
  logic [1:0][BUS_WIDTH-1:0]     req_a, req_b;
  logic [1:0][3:0]               req_cmd;
  logic                          flag_cmd;

  assign req_valid = {bus.req1_valid, bus.req0_valid};
  assign rsp_ready = {bus.rsp1_ready, bus.rsp0_ready};
  assign req_a     = {bus.req1_a, bus.req0_a};
  assign req_b     = {bus.req1_b, bus.req0_b};
  assign req_cmd   = {bus.req1_cmd, bus.req0_cmd};

  // Only add and the three compares produce a meaningful flag.
  assign flag_cmd = (alu_cmd_q == 4'd0) || (alu_cmd_q inside {[4'd7:4'd9]});

  always_comb begin
    grant = '0;
    if (state_q == IDLE) begin
      if (req_valid[prio_q])       grant[prio_q]  = 1'b1;
      else if (req_valid[~prio_q]) grant[~prio_q] = 1'b1;
    end
  end

  always_comb begin
    state_d     = state_q;
    prio_d      = prio_q;
    owner_d     = owner_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_cmd_d   = alu_cmd_q;
    rsp_valid_d = rsp_valid_q;
    rsp_flag_d  = rsp_flag_q;
    rsp_out_d   = rsp_out_q;
    case (state_q)
      IDLE: if (|grant) begin
        owner_d   = grant[1];
        alu_a_d   = req_a[grant[1]];
        alu_b_d   = req_b[grant[1]];
        alu_cmd_d = req_cmd[grant[1]];
        state_d   = EXEC;
      end
      EXEC: begin
        rsp_out_d[owner_q]   = bus.alu_out;
        rsp_flag_d[owner_q]  = flag_cmd & bus.alu_overflow;
        rsp_valid_d[owner_q] = 1'b1;
        state_d              = RESP;
      end
      RESP: if (rsp_ready[owner_q]) begin
        rsp_valid_d[owner_q] = 1'b0;
        prio_d               = ~owner_q;
        state_d              = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      prio_q      <= 1'b0;
      owner_q     <= 1'b0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_cmd_q   <= '0;
      rsp_valid_q <= '0;
      rsp_flag_q  <= '0;
      rsp_out_q   <= '0;
    end else begin
      state_q     <= state_d;
      prio_q      <= prio_d;
      owner_q     <= owner_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_cmd_q   <= alu_cmd_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_flag_q  <= rsp_flag_d;
      rsp_out_q   <= rsp_out_d;
    end
  end

  assign bus.req0_ready  = grant[0];
  assign bus.req1_ready  = grant[1];
  assign bus.alu_a       = alu_a_q;
  assign bus.alu_b       = alu_b_q;
  assign bus.alu_command = alu_cmd_q;
  assign bus.rsp0_valid  = rsp_valid_q[0];
  assign bus.rsp0_out    = rsp_out_q[0];
  assign bus.rsp0_flag   = rsp_flag_q[0];
  assign bus.rsp1_valid  = rsp_valid_q[1];
  assign bus.rsp1_out    = rsp_out_q[1];
  assign bus.rsp1_flag   = rsp_flag_q[1];
endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: behavioural ALU stub, expected-result queue
// filled on accept and drained on each response handshake.
module tb_alu_arbiter;
  localparam int W = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  alu_arbiter_if #(.BUS_WIDTH(W)) bus();
  alu_arbiter #(.BUS_WIDTH(W)) dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct {int id; logic [7:0] out; logic flag;} sb_t;
  sb_t sb[$];
  int  gnt_q[$];
  int  n_cmp = 0;
  int  n_err = 0;

  // Raw ALU: {overflow, out}. Sub and shift give a carry/borrow the arbiter must mask.
  function automatic logic [8:0] alu_fn(input logic [3:0] c, input logic [7:0] a, input logic [7:0] b);
    logic [8:0] r;
    r = '0;
    case (c)
      4'd0: r = {1'b0, a} + {1'b0, b};
      4'd1: r = {1'b0, a} - {1'b0, b};
      4'd2: r = {1'b0, a & b};
      4'd3: r = {1'b0, a | b};
      4'd4: r = {1'b0, a ^ b};
      4'd5: r = {1'b0, ~a};
      4'd6: r = {a, 1'b0};
      4'd7: r = {a == b, 8'h00};
      4'd8: r = {a > b, 8'h00};
      4'd9: r = {a < b, 8'h00};
      default: r = '0;
    endcase
    return r;
  endfunction

  function automatic logic [8:0] exp_fn(input logic [3:0] c, input logic [7:0] a, input logic [7:0] b);
    logic [8:0] r;
    r = alu_fn(c, a, b);
    if (!(c inside {4'd0, 4'd7, 4'd8, 4'd9})) r[8] = 1'b0;
    return r;
  endfunction

  always_comb {bus.alu_overflow, bus.alu_out} = alu_fn(bus.alu_command, bus.alu_a, bus.alu_b);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic timeout(input string tag);
    n_cmp++;
    n_err++;
    $error("FAIL %s: observed no event within budget, expected one", tag);
  endtask

  task automatic drive(input int n, input logic v, input logic [7:0] a, input logic [7:0] b, input logic [3:0] c);
    if (n == 0) begin bus.req0_valid = v; bus.req0_a = a; bus.req0_b = b; bus.req0_cmd = c; end
    else        begin bus.req1_valid = v; bus.req1_a = a; bus.req1_b = b; bus.req1_cmd = c; end
  endtask

  function automatic logic rdy(input int n);
    return (n == 0) ? bus.req0_ready : bus.req1_ready;
  endfunction

  function automatic logic rvld(input int n);
    return (n == 0) ? bus.rsp0_valid : bus.rsp1_valid;
  endfunction

  task automatic check_rsp(input int n, input logic [7:0] out, input logic flag);
    sb_t e;
    if (sb.size() == 0) begin
      n_cmp++;
      n_err++;
      $error("FAIL unexpected_rsp: observed response on port %0d, expected none", n);
    end else begin
      e = sb.pop_front();
      chk("rsp_owner", n, e.id);
      chk("rsp_out", {24'h0, out}, {24'h0, e.out});
      chk("rsp_flag", {31'h0, flag}, {31'h0, e.flag});
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (bus.rsp0_valid && bus.rsp0_ready) check_rsp(0, bus.rsp0_out, bus.rsp0_flag);
      if (bus.rsp1_valid && bus.rsp1_ready) check_rsp(1, bus.rsp1_out, bus.rsp1_flag);
    end
  end

  task automatic wait_ready(input int n, output logic ok);
    int cnt = 0;
    ok = 1'b0;
    while (!ok && cnt < 30) begin
      @(negedge clk);
      ok = rdy(n);
      cnt++;
    end
    if (!ok) timeout("wait_ready");
  endtask

  task automatic wait_rsp(input int n);
    int cnt = 0;
    logic seen = 1'b0;
    while (!seen && cnt < 30) begin
      @(negedge clk);
      seen = rvld(n);
      cnt++;
    end
    if (!seen) timeout("wait_rsp");
  endtask

  task automatic run_op(input int n, input logic [7:0] a, input logic [7:0] b, input logic [3:0] c,
                        input logic [7:0] eo, input logic ef);
    logic ok;
    drive(n, 1'b1, a, b, c);
    wait_ready(n, ok);
    if (ok) sb.push_back('{n, eo, ef});
    @(posedge clk); #1;
    drive(n, 1'b0, a, b, c);
    if (ok) wait_rsp(n);
    @(posedge clk); #1;
  endtask

  task automatic wait_drain();
    int cnt = 0;
    while (sb.size() != 0 && cnt < 60) begin
      @(negedge clk);
      cnt++;
    end
    if (sb.size() != 0) timeout("drain");
    @(posedge clk); #1;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    sb.delete();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_rsp0_valid"}, {31'h0, bus.rsp0_valid}, 32'h0);
    chk({tag, "_rsp1_valid"}, {31'h0, bus.rsp1_valid}, 32'h0);
    chk({tag, "_rsp0_out"}, {24'h0, bus.rsp0_out}, 32'h0);
    chk({tag, "_rsp0_flag"}, {31'h0, bus.rsp0_flag}, 32'h0);
    chk({tag, "_alu_a"}, {24'h0, bus.alu_a}, 32'h0);
    chk({tag, "_alu_b"}, {24'h0, bus.alu_b}, 32'h0);
  endtask

  logic [7:0] cur_a [2];
  logic [7:0] cur_b [2];
  logic [3:0] cur_c [2];
  logic       took  [2];
  logic [8:0] e;
  logic [7:0] held;
  logic       ok;
  int         acc, cyc;

  initial begin
    reset = 1'b1;
    drive(0, 1'b0, 8'h0, 8'h0, 4'h0);
    drive(1, 1'b0, 8'h0, 8'h0, 4'h0);
    bus.rsp0_ready = 1'b1;
    bus.rsp1_ready = 1'b1;

    // Reset state
    repeat (2) @(negedge clk);
    chk_zero("reset");
    chk("reset_alu_cmd", {28'h0, bus.alu_command}, 32'h0);
    chk("reset_rsp1_flag", {31'h0, bus.rsp1_flag}, 32'h0);
    @(posedge clk); #1 reset = 1'b0;

    // Step 1: first add with exact latency
    drive(0, 1'b1, 8'h05, 8'h03, 4'd0);
    @(negedge clk);
    chk("t1_req0_ready", {31'h0, bus.req0_ready}, 32'h1);
    chk("t1_req1_ready", {31'h0, bus.req1_ready}, 32'h0);
    sb.push_back('{0, 8'h08, 1'b0});
    @(posedge clk); #1;
    drive(0, 1'b0, 8'h00, 8'h00, 4'd0);
    @(negedge clk);
    chk("t1_exec_valid", {31'h0, bus.rsp0_valid}, 32'h0);
    chk("t1_alu_a", {24'h0, bus.alu_a}, 32'h05);
    chk("t1_alu_b", {24'h0, bus.alu_b}, 32'h03);
    @(negedge clk);
    chk("t1_rsp_valid_T2", {31'h0, bus.rsp0_valid}, 32'h1);
    chk("t1_rsp1_valid", {31'h0, bus.rsp1_valid}, 32'h0);
    @(posedge clk); #1;

    // Step 2: add overflow, sub, sub with masked borrow
    run_op(0, 8'hFF, 8'h01, 4'd0, 8'h00, 1'b1);
    run_op(0, 8'h05, 8'h03, 4'd1, 8'h02, 1'b0);
    run_op(0, 8'h03, 8'h05, 4'd1, 8'hFE, 1'b0);

    // Step 3: both requesters always valid -> strict alternation from priority 0
    pulse_reset();
    for (int n = 0; n < 2; n++) begin
      cur_a[n] = 8'($urandom_range(0, 255));
      cur_b[n] = 8'($urandom_range(0, 255));
      cur_c[n] = 4'($urandom_range(0, 15));
      took[n]  = 1'b0;
      drive(n, 1'b1, cur_a[n], cur_b[n], cur_c[n]);
    end
    acc = 0;
    cyc = 0;
    while (acc < 8 && cyc < 100) begin
      @(negedge clk);
      for (int n = 0; n < 2; n++) begin
        if (rdy(n)) begin
          e = exp_fn(cur_c[n], cur_a[n], cur_b[n]);
          sb.push_back('{n, e[7:0], e[8]});
          gnt_q.push_back(n);
          took[n] = 1'b1;
          acc++;
        end
      end
      @(posedge clk); #1;
      for (int n = 0; n < 2; n++) begin
        if (took[n]) begin
          cur_a[n] = 8'($urandom_range(0, 255));
          cur_b[n] = 8'($urandom_range(0, 255));
          cur_c[n] = 4'($urandom_range(0, 15));
          drive(n, acc < 8, cur_a[n], cur_b[n], cur_c[n]);
          took[n] = 1'b0;
        end
      end
      cyc++;
    end
    if (acc < 8) timeout("t3_grants");
    drive(0, 1'b0, 8'h0, 8'h0, 4'h0);
    drive(1, 1'b0, 8'h0, 8'h0, 4'h0);
    for (int i = 0; i < gnt_q.size(); i++) chk("t3_grant_order", gnt_q[i], i % 2);
    wait_drain();

    // Step 4: stalled response blocks the other requester
    bus.rsp1_ready = 1'b0;
    drive(1, 1'b1, 8'h40, 8'h02, 4'd0);
    wait_ready(1, ok);
    if (ok) sb.push_back('{1, 8'h42, 1'b0});
    @(posedge clk); #1;
    drive(1, 1'b0, 8'h00, 8'h00, 4'd0);
    drive(0, 1'b1, 8'h10, 8'h20, 4'd0);
    wait_rsp(1);
    held = bus.rsp1_out;
    chk("t4_held_out", {24'h0, held}, 32'h42);
    repeat (5) begin
      @(negedge clk);
      chk("t4_rsp1_valid", {31'h0, bus.rsp1_valid}, 32'h1);
      chk("t4_rsp1_stable", {24'h0, bus.rsp1_out}, {24'h0, held});
      chk("t4_req0_blocked", {31'h0, bus.req0_ready}, 32'h0);
    end
    @(posedge clk); #1 bus.rsp1_ready = 1'b1;
    @(negedge clk);
    chk("t4_req0_in_resp", {31'h0, bus.req0_ready}, 32'h0);
    @(negedge clk);
    chk("t4_req0_granted", {31'h0, bus.req0_ready}, 32'h1);
    if (bus.req0_ready) sb.push_back('{0, 8'h30, 1'b0});
    @(posedge clk); #1;
    drive(0, 1'b0, 8'h00, 8'h00, 4'd0);
    wait_drain();

    // Step 5: compare flags and out-of-range command
    run_op(1, 8'h09, 8'h04, 4'd8, 8'h00, 1'b1);
    run_op(1, 8'h09, 8'h04, 4'd9, 8'h00, 1'b0);
    run_op(1, 8'h77, 8'h11, 4'hC, 8'h00, 1'b0);
    run_op(1, 8'h81, 8'h00, 4'd6, 8'h02, 1'b0);

    // Step 6a: reset during EXEC
    run_op(0, 8'h21, 8'h12, 4'd0, 8'h33, 1'b0);
    drive(0, 1'b1, 8'h05, 8'h03, 4'd0);
    wait_ready(0, ok);
    @(posedge clk); #1;
    reset = 1'b1;
    sb.delete();
    drive(0, 1'b0, 8'h00, 8'h00, 4'd0);
    #1 chk_zero("t6_exec");
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("t6_exec_no_rsp", {30'h0, bus.rsp1_valid, bus.rsp0_valid}, 32'h0);
    end
    @(posedge clk); #1;

    // Step 6b: reset during RESP, after priority has moved to requester 1
    run_op(0, 8'h11, 8'h22, 4'd0, 8'h33, 1'b0);
    bus.rsp0_ready = 1'b0;
    drive(0, 1'b1, 8'h44, 8'h01, 4'd0);
    wait_ready(0, ok);
    @(posedge clk); #1;
    drive(0, 1'b0, 8'h00, 8'h00, 4'd0);
    wait_rsp(0);
    @(posedge clk); #1;
    reset = 1'b1;
    sb.delete();
    #1 chk_zero("t6_resp");
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    bus.rsp0_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("t6_resp_no_rsp", {30'h0, bus.rsp1_valid, bus.rsp0_valid}, 32'h0);
    end
    @(posedge clk); #1;

    // Tie after reset goes to requester 0
    drive(0, 1'b1, 8'h01, 8'h01, 4'd0);
    drive(1, 1'b1, 8'h02, 8'h02, 4'd0);
    @(negedge clk);
    chk("t6_tie_req0", {31'h0, bus.req0_ready}, 32'h1);
    chk("t6_tie_req1", {31'h0, bus.req1_ready}, 32'h0);
    if (bus.req0_ready) sb.push_back('{0, 8'h02, 1'b0});
    @(posedge clk); #1;
    drive(0, 1'b0, 8'h00, 8'h00, 4'd0);
    wait_ready(1, ok);
    if (ok) sb.push_back('{1, 8'h04, 1'b0});
    @(posedge clk); #1;
    drive(1, 1'b0, 8'h00, 8'h00, 4'd0);
    wait_drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
